// File: rtl/mcycle_seq.sv
// mcycle_seq: machine-cycle sequencer for the 4004 core.
// Produces the eight-phase cycle A1 A2 A3 M1 M2 X1 X2 X3, captures instruction
// nibbles from the 4-bit bus, decodes the opcode, tracks one- and two-cycle
// instructions, and issues PC-increment and execute strobes.
//
// Build option: define FIN_TWO_CYCLE_EN to make FIN a two-cycle instruction
// whose second cycle is an indirect fetch (PC increment suppressed).
// Without it FIN completes in one cycle and indirect_o is tied low.
//
// Every output is registered or decoded purely from registered state, so there
// is no combinational path from data_i or stall_i to any output.

module mcycle_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_i,
    input  logic       stall_i,
    output logic [2:0] phase_o,
    output logic       sync_o,
    output logic [7:0] opcode_o,
    output logic [3:0] opr_o,
    output logic [3:0] opa_o,
    output logic [7:0] arg_o,
    output logic       second_o,
    output logic       indirect_o,
    output logic       pc_inc_o,
    output logic       exec_o
);

    // Phase encoding, A1 = 0 ... X3 = 7
    localparam logic [2:0] PhA1 = 3'd0;
    localparam logic [2:0] PhA3 = 3'd2;
    localparam logic [2:0] PhM1 = 3'd3;
    localparam logic [2:0] PhM2 = 3'd4;
    localparam logic [2:0] PhX1 = 3'd5;
    localparam logic [2:0] PhX3 = 3'd7;

    // Opcode encodings for the nibble pairs that do not map to {OPR,4'h0}
    localparam logic [7:0] OpNop = 8'h00;
    localparam logic [7:0] OpFim = 8'h20;
    localparam logic [7:0] OpSrc = 8'h21;
    localparam logic [7:0] OpFin = 8'h30;
    localparam logic [7:0] OpJin = 8'h31;

    typedef enum logic {
        CycFirst,
        CycSecond
    } cyc_e;

    // Sequencer state
    logic [2:0] r_phase;
    cyc_e       r_cyc;

    // Instruction holding registers
    logic [3:0] r_opr;
    logic [3:0] r_opa;
    logic [7:0] r_opcode;
    logic       r_two;
    logic [7:0] r_arg;

    // Next-state and decode wires
    logic [2:0] w_phase_next;
    cyc_e       w_cyc_next;
    logic [7:0] w_dec_opcode;
    logic       w_dec_two;
    logic       w_second;
    logic       w_indirect;

    // Decode of {captured OPR, OPA on the bus}; sampled only at the M2 edge
    always_comb begin
        w_dec_opcode = {r_opr, 4'h0};
        w_dec_two    = 1'b0;
        case (r_opr)
            4'h1: begin
                w_dec_two = 1'b1;                  // JCN
            end
            4'h2: begin
                w_dec_opcode = data_i[0] ? OpSrc : OpFim;
                w_dec_two    = ~data_i[0];         // FIM carries a data byte
            end
            4'h3: begin
                w_dec_opcode = data_i[0] ? OpJin : OpFin;
`ifdef FIN_TWO_CYCLE_EN
                w_dec_two    = ~data_i[0];         // FIN fetches indirectly
`else
                w_dec_two    = 1'b0;
`endif
            end
            4'h4, 4'h5, 4'h7: begin
                w_dec_two = 1'b1;                  // JUN, JMS, ISZ
            end
            4'hE: begin
                w_dec_opcode = {4'hE, data_i};
            end
            4'hF: begin
                if (data_i == 4'hE || data_i == 4'hF) begin
                    w_dec_opcode = OpNop;
                end else begin
                    w_dec_opcode = {4'hF, data_i};
                end
            end
            default: begin
                w_dec_opcode = {r_opr, 4'h0};
            end
        endcase
    end

    // Phase advance with X3 stall hold, and FIRST/SECOND cycle selection
    always_comb begin
        w_phase_next = r_phase + 3'd1;
        w_cyc_next   = r_cyc;
        if (r_phase == PhX3) begin
            if (stall_i) begin
                w_phase_next = PhX3;
            end else if (r_cyc == CycFirst && r_two) begin
                w_cyc_next = CycSecond;
            end else begin
                w_cyc_next = CycFirst;
            end
        end
    end

    // Sequencer state register; reset aborts any cycle in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PhA1;
            r_cyc   <= CycFirst;
        end else begin
            r_phase <= w_phase_next;
            r_cyc   <= w_cyc_next;
        end
    end

    // Bus nibble capture: first word into OPR/OPA/opcode, second word into arg
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opr    <= 4'h0;
            r_opa    <= 4'h0;
            r_opcode <= OpNop;
            r_two    <= 1'b0;
            r_arg    <= 8'h00;
        end else begin
            if (r_phase == PhM1) begin
                if (r_cyc == CycFirst) begin
                    r_opr <= data_i;
                end else begin
                    r_arg[7:4] <= data_i;
                end
            end
            if (r_phase == PhM2) begin
                if (r_cyc == CycFirst) begin
                    r_opa    <= data_i;
                    r_opcode <= w_dec_opcode;
                    r_two    <= w_dec_two;
                end else begin
                    r_arg[3:0] <= data_i;
                end
            end
        end
    end

    // Output decode from registered state only
    always_comb begin
        w_second = (r_cyc == CycSecond);
`ifdef FIN_TWO_CYCLE_EN
        w_indirect = w_second && (r_opcode == OpFin);
`else
        w_indirect = 1'b0;
`endif
        phase_o    = r_phase;
        sync_o     = (r_phase == PhX3);
        opcode_o   = r_opcode;
        opr_o      = r_opr;
        opa_o      = r_opa;
        arg_o      = r_arg;
        second_o   = w_second;
        indirect_o = w_indirect;
        pc_inc_o   = (r_phase == PhA3) && !w_indirect;
        // r_two stays set through the SECOND cycle, so this fires in the final cycle only
        exec_o     = (r_phase == PhX1) && (w_second || !r_two);
    end

endmodule

// File: tb/tb_mcycle_seq.sv
// Bench for mcycle_seq: directed scenarios followed by random instructions,
// checked against an instruction-level model of the sequencer.
// Honours FIN_TWO_CYCLE_EN the same way as the design.

module tb_mcycle_seq;

    logic       clk;
    logic       rst;
    logic [3:0] data_i;
    logic       stall_i;
    logic [2:0] phase_o;
    logic       sync_o;
    logic [7:0] opcode_o;
    logic [3:0] opr_o;
    logic [3:0] opa_o;
    logic [7:0] arg_o;
    logic       second_o;
    logic       indirect_o;
    logic       pc_inc_o;
    logic       exec_o;

    int checks = 0;
    int errors = 0;

    mcycle_seq dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .stall_i    (stall_i),
        .phase_o    (phase_o),
        .sync_o     (sync_o),
        .opcode_o   (opcode_o),
        .opr_o      (opr_o),
        .opa_o      (opa_o),
        .arg_o      (arg_o),
        .second_o   (second_o),
        .indirect_o (indirect_o),
        .pc_inc_o   (pc_inc_o),
        .exec_o     (exec_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference opcode from the instruction-set rules
    function automatic logic [7:0] ref_opcode(input logic [3:0] hi, input logic [3:0] lo);
        if (hi == 4'h2) return lo[0] ? 8'h21 : 8'h20;
        if (hi == 4'h3) return lo[0] ? 8'h31 : 8'h30;
        if (hi == 4'hE) return {4'hE, lo};
        if (hi == 4'hF) return (lo >= 4'hE) ? 8'h00 : {4'hF, lo};
        return {hi, 4'h0};
    endfunction

    // Reference two-cycle membership
    function automatic logic ref_two(input logic [3:0] hi, input logic [3:0] lo);
        logic [15:0] always_two;
        always_two = 16'h00B2;  // JCN(1), JUN(4), JMS(5), ISZ(7)
        if (always_two[hi]) return 1'b1;
        if (hi == 4'h2) return !lo[0];
`ifdef FIN_TWO_CYCLE_EN
        if (hi == 4'h3) return !lo[0];
`endif
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_phase", {5'd0, phase_o}, 8'd0);
        chk("rst_sync", {7'd0, sync_o}, 8'd0);
        chk("rst_opcode", opcode_o, 8'h00);
        chk("rst_opr", {4'd0, opr_o}, 8'd0);
        chk("rst_opa", {4'd0, opa_o}, 8'd0);
        chk("rst_arg", arg_o, 8'h00);
        chk("rst_second", {7'd0, second_o}, 8'd0);
        chk("rst_indirect", {7'd0, indirect_o}, 8'd0);
        chk("rst_pc_inc", {7'd0, pc_inc_o}, 8'd0);
        chk("rst_exec", {7'd0, exec_o}, 8'd0);
    endtask

    // Expected outputs while the DUT shows phase p of a machine cycle
    task automatic check_phase(input int p, input logic second, input logic ind,
                               input logic fin, input logic [7:0] opc,
                               input logic [3:0] opr, input logic [3:0] opa,
                               input logic [7:0] arg);
        chk("phase", {5'd0, phase_o}, 8'(p));
        chk("sync", {7'd0, sync_o}, {7'd0, p == 7});
        chk("second", {7'd0, second_o}, {7'd0, second});
        chk("indirect", {7'd0, indirect_o}, {7'd0, ind});
        chk("pc_inc", {7'd0, pc_inc_o}, {7'd0, (p == 2) && !ind});
        chk("exec", {7'd0, exec_o}, {7'd0, (p == 5) && fin});
        if (second || p >= 5) begin
            chk("opcode", opcode_o, opc);
            chk("opr", {4'd0, opr_o}, {4'd0, opr});
            chk("opa", {4'd0, opa_o}, {4'd0, opa});
        end
        if (second && p >= 5) chk("arg", arg_o, arg);
    endtask

    // One machine cycle starting with the DUT at A1. Bus carries hi/lo in the
    // M1/M2 windows and junk elsewhere; stall_i is random outside X3.
    // n_ph < 8 stops early, leaving the DUT at phase n_ph.
    task automatic run_mcycle(input logic [3:0] hi, input logic [3:0] lo, input int stall_n,
                              input logic second, input logic ind, input logic fin,
                              input logic [7:0] opc, input logic [3:0] opr,
                              input logic [3:0] opa, input logic [7:0] arg,
                              input int n_ph);
        for (int p = 0; p < n_ph && p < 7; p++) begin
            check_phase(p, second, ind, fin, opc, opr, opa, arg);
            data_i  = (p == 3) ? hi : (p == 4) ? lo : 4'($urandom);
            stall_i = 1'($urandom);
            tick();
        end
        if (n_ph >= 8) begin
            for (int s = 0; s <= stall_n; s++) begin
                check_phase(7, second, ind, fin, opc, opr, opa, arg);
                data_i  = 4'($urandom);
                stall_i = (s < stall_n);
                tick();
            end
            stall_i = 1'b0;
        end
    endtask

    task automatic run_instr(input logic [3:0] hi, input logic [3:0] lo,
                             input logic [7:0] arg, input int st1, input int st2);
        logic [7:0] opc;
        logic       two;
        logic       ind;
        opc = ref_opcode(hi, lo);
        two = ref_two(hi, lo);
        ind = two && (hi == 4'h3);
        run_mcycle(hi, lo, st1, 1'b0, 1'b0, !two, opc, hi, lo, 8'h00, 8);
        if (two) run_mcycle(arg[7:4], arg[3:0], st2, 1'b1, ind, 1'b1, opc, hi, lo, arg, 8);
    endtask

    initial begin
        logic [3:0] jcn_lo;
        rst     = 1'b1;
        stall_i = 1'b1;  // reset must win over stall
        data_i  = 4'h0;
        tick();
        tick();
        check_reset_vals();
        stall_i = 1'b0;
        rst     = 1'b0;

        // Bus idle at zero: NOPs
        run_instr(4'h0, 4'h0, 8'h00, 0, 0);
        run_instr(4'h0, 4'h0, 8'h00, 0, 0);
        // LDM 5
        run_instr(4'hD, 4'h5, 8'h00, 0, 0);
        // JUN 0x123
        run_instr(4'h4, 4'h1, 8'h23, 0, 0);
        // FIN
        run_instr(4'h3, 4'h0, 8'hA7, 0, 0);
        // JMS with a 5-clock stall in X3 of the first cycle
        run_instr(4'h5, 4'h6, 8'h9C, 5, 0);
        // F,E decodes to NOP
        run_instr(4'hF, 4'hE, 8'h00, 0, 0);
        // Stall inside a second cycle
        run_instr(4'h2, 4'h4, 8'h5A, 1, 3);

        // JCN: full first cycle, then reset pulsed at M2 of its second cycle
        jcn_lo = 4'($urandom);
        run_mcycle(4'h1, jcn_lo, 0, 1'b0, 1'b0, 1'b0, 8'h10, 4'h1, jcn_lo, 8'h00, 8);
        run_mcycle(4'h6, 4'h1, 0, 1'b1, 1'b0, 1'b1, 8'h10, 4'h1, jcn_lo, 8'h00, 4);
        chk("abort_phase", {5'd0, phase_o}, 8'd4);
        data_i  = 4'($urandom);
        stall_i = 1'b1;
        rst     = 1'b1;
        tick();
        check_reset_vals();
        rst     = 1'b0;
        stall_i = 1'b0;
        // Next cycle must be a FIRST cycle
        run_instr(4'hD, 4'h9, 8'h00, 0, 0);

        // Random instruction stream
        for (int i = 0; i < 60; i++) begin
            logic [3:0] hi;
            logic [3:0] lo;
            logic [7:0] arg;
            int         st1;
            int         st2;
            hi  = 4'($urandom);
            lo  = 4'($urandom);
            arg = 8'($urandom);
            st1 = ($urandom_range(1, 0) == 1) ? int'($urandom_range(3, 0)) : 0;
            st2 = ($urandom_range(1, 0) == 1) ? int'($urandom_range(3, 0)) : 0;
            run_instr(hi, lo, arg, st1, st2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
